// File: rtl/fifo_param.sv
// Synchronous single-clock FIFO with occupancy count, programmable almost-full/empty
// levels, sticky overflow/underflow flags and a registered read port.
module fifo_param #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr,
   input  logic [DATA_W-1:0] wr_in,
   input  logic              rd,
   output logic [DATA_W-1:0] rd_out,
   output logic              rd_valid,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   count,
   input  logic [ADDR_W:0]   af_thresh,
   input  logic [ADDR_W:0]   ae_thresh,
   output logic              almost_full,
   output logic              almost_empty,
   output logic              overflow,
   output logic              underflow,
   input  logic              err_clr
);

   localparam int             DEPTH_N = 1 << ADDR_W;
   localparam logic [ADDR_W:0] DEPTH  = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] ONE    = {{ADDR_W{1'b0}}, 1'b1};

   if (ADDR_W < 2 || ADDR_W > 12) begin : g_bad_addr_w
      $error("fifo_param: ADDR_W must be in 2..12");
   end

   logic [DATA_W-1:0] mem [0:DEPTH_N-1];
   logic [ADDR_W:0]   wptr, rptr;
   logic [1:0]        rst_q;
   logic              rst_i;
   logic              wr_ok, rd_ok;

   // Reset asserts immediately, releases two edges after rst rises.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rst_q <= 2'b00;
      else      rst_q <= {rst_q[0], 1'b1};
   end
   assign rst_i = rst_q[1];

   assign count        = wptr - rptr;
   assign full         = (count == DEPTH);
   assign empty        = (count == '0);
   assign almost_full  = (count >= af_thresh);
   assign almost_empty = (count <= ae_thresh);

   assign wr_ok = wr && !full;
   assign rd_ok = rd && !empty;

   always_ff @(posedge clk) begin
      if (wr_ok) mem[wptr[ADDR_W-1:0]] <= wr_in;
   end

   always_ff @(posedge clk or negedge rst_i) begin
      if (!rst_i) begin
         wptr      <= '0;
         rptr      <= '0;
         rd_out    <= '0;
         rd_valid  <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_ok) wptr <= wptr + ONE;
         if (rd_ok) begin
            rptr   <= rptr + ONE;
            rd_out <= mem[rptr[ADDR_W-1:0]];
         end
         rd_valid <= rd_ok;
         // A new error wins over a coincident clear.
         if (wr && full)   overflow  <= 1'b1;
         else if (err_clr) overflow  <= 1'b0;
         if (rd && empty)  underflow <= 1'b1;
         else if (err_clr) underflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fifo_param.sv
// Bench for fifo_param: table-driven fill/drain plus directed wrap, boundary,
// threshold, error-flag and async-reset sequences against a queue model.
module tb_fifo_param;

   logic       clk = 1'b0;
   logic       rst;
   logic       wr, rd, err_clr;
   logic [7:0] wr_in;
   logic [7:0] rd_out;
   logic       rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
   logic [4:0] count, af_thresh, ae_thresh;

   fifo_param #(.DATA_W(8), .ADDR_W(4)) dut (
      .clk(clk), .rst(rst), .wr(wr), .wr_in(wr_in), .rd(rd),
      .rd_out(rd_out), .rd_valid(rd_valid), .full(full), .empty(empty),
      .count(count), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
      .almost_full(almost_full), .almost_empty(almost_empty),
      .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         errors = 0;
   int         mcount;
   logic       movf, munf;
   logic [7:0] last_rd;
   logic [7:0] q[$];
   logic [7:0] sb[$];

   typedef struct {
      logic       w;
      logic [7:0] d;
      logic       r;
      logic       c;
      int         cnt;
      logic       ovf;
      logic       unf;
   } vec_t;
   vec_t tbl[34];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      sb.delete();
      mcount  = 0;
      movf    = 1'b0;
      munf    = 1'b0;
      last_rd = 8'h00;
   endtask

   task automatic cycle(input logic w, input logic [7:0] d, input logic r, input logic c);
      logic wacc, racc;
      logic [7:0] e;
      wr = w; wr_in = d; rd = r; err_clr = c;
      wacc = w && (mcount < 16);
      racc = r && (mcount > 0);
      if (w && mcount == 16) movf = 1'b1; else if (c) movf = 1'b0;
      if (r && mcount == 0)  munf = 1'b1; else if (c) munf = 1'b0;
      if (racc) sb.push_back(q.pop_front());
      if (wacc) q.push_back(d);
      mcount = mcount + int'(wacc) - int'(racc);
      @(posedge clk); #1;
      wr = 1'b0; rd = 1'b0; err_clr = 1'b0;
      chk("rd_valid", {31'b0, rd_valid}, {31'b0, racc});
      if (rd_valid === 1'b1) begin
         if (sb.size() == 0) chk("rd_valid_unexpected", 32'd1, 32'd0);
         else begin
            e = sb.pop_front();
            chk("rd_out", {24'b0, rd_out}, {24'b0, e});
            last_rd = e;
         end
      end else chk("rd_out_hold", {24'b0, rd_out}, {24'b0, last_rd});
      chk("count", {27'b0, count}, mcount);
      chk("full", {31'b0, full}, {31'b0, mcount == 16});
      chk("empty", {31'b0, empty}, {31'b0, mcount == 0});
      chk("overflow", {31'b0, overflow}, {31'b0, movf});
      chk("underflow", {31'b0, underflow}, {31'b0, munf});
      chk("almost_full", {31'b0, almost_full}, {31'b0, mcount >= int'(af_thresh)});
      chk("almost_empty", {31'b0, almost_empty}, {31'b0, mcount <= int'(ae_thresh)});
   endtask

   task automatic do_reset();
      rst = 1'b0;
      #1;
      model_reset();
      chk("rst_count", {27'b0, count}, 32'd0);
      chk("rst_empty", {31'b0, empty}, 32'd1);
      chk("rst_full", {31'b0, full}, 32'd0);
      chk("rst_rd_valid", {31'b0, rd_valid}, 32'd0);
      chk("rst_rd_out", {24'b0, rd_out}, 32'd0);
      chk("rst_ovf", {31'b0, overflow}, 32'd0);
      chk("rst_unf", {31'b0, underflow}, 32'd0);
      @(negedge clk) rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      wr = 0; rd = 0; err_clr = 0; wr_in = 0;
      af_thresh = 5'd12; ae_thresh = 5'd3;
      do_reset();
      chk("rst_almost_empty", {31'b0, almost_empty}, 32'd1);
      chk("rst_almost_full", {31'b0, almost_full}, 32'd0);

      // Fill, overflow write, drain, underflow read
      for (int i = 0; i < 16; i++) tbl[i] = '{1'b1, 8'(i), 1'b0, 1'b0, i + 1, 1'b0, 1'b0};
      tbl[16] = '{1'b1, 8'hAA, 1'b0, 1'b0, 16, 1'b1, 1'b0};
      for (int i = 0; i < 16; i++) tbl[17 + i] = '{1'b0, 8'h00, 1'b1, 1'b0, 15 - i, 1'b1, 1'b0};
      tbl[33] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b1};
      for (int i = 0; i < 34; i++) begin
         cycle(tbl[i].w, tbl[i].d, tbl[i].r, tbl[i].c);
         chk("tbl_count", {27'b0, count}, tbl[i].cnt);
         chk("tbl_ovf", {31'b0, overflow}, {31'b0, tbl[i].ovf});
         chk("tbl_unf", {31'b0, underflow}, {31'b0, tbl[i].unf});
         if (i == 15) chk("fill_full", {31'b0, full}, 32'd1);
      end
      chk("drain_hold_0f", {24'b0, rd_out}, 32'h0F);
      chk("drain_empty", {31'b0, empty}, 32'd1);
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      chk("clr_ovf", {31'b0, overflow}, 32'd0);
      chk("clr_unf", {31'b0, underflow}, 32'd0);

      // Wrap: pointers cross the DEPTH boundary
      do_reset();
      for (int i = 0; i < 10; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
      for (int i = 0; i < 12; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
      for (int i = 0; i < 12; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
      chk("wrap_count", {27'b0, count}, 32'd0);
      chk("wrap_wptr_msb", {31'b0, dut.wptr[4]}, 32'd1);
      chk("wrap_rptr", {27'b0, dut.rptr}, 32'd22);

      // Boundary: wr&&rd while full, then while empty
      do_reset();
      for (int i = 0; i < 16; i++) cycle(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0);
      cycle(1'b1, 8'hEE, 1'b1, 1'b0);
      chk("full_wr_rd_count", {27'b0, count}, 32'd15);
      chk("full_wr_rd_ovf", {31'b0, overflow}, 32'd1);
      chk("full_wr_rd_data", {24'b0, rd_out}, 32'h40);
      for (int i = 0; i < 15; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
      cycle(1'b1, 8'h77, 1'b1, 1'b1);
      chk("empty_wr_rd_count", {27'b0, count}, 32'd1);
      chk("empty_wr_rd_unf", {31'b0, underflow}, 32'd1);
      chk("empty_wr_rd_valid", {31'b0, rd_valid}, 32'd0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);

      // Thresholds and error-clear priority
      do_reset();
      af_thresh = 5'd12; ae_thresh = 5'd3;
      for (int i = 1; i <= 16; i++) begin
         cycle(1'b1, 8'(i), 1'b0, 1'b0);
         if (i == 11) chk("af_below", {31'b0, almost_full}, 32'd0);
         if (i == 12) chk("af_rise", {31'b0, almost_full}, 32'd1);
         if (i == 3)  chk("ae_at3", {31'b0, almost_empty}, 32'd1);
         if (i == 4)  chk("ae_fall", {31'b0, almost_empty}, 32'd0);
      end
      ae_thresh = 5'd16; #1;
      chk("ae_ge_depth", {31'b0, almost_empty}, 32'd1);
      cycle(1'b1, 8'hBB, 1'b0, 1'b1);
      chk("set_wins", {31'b0, overflow}, 32'd1);
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      chk("lone_clr", {31'b0, overflow}, 32'd0);
      ae_thresh = 5'd3;
      for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
      af_thresh = 5'd0; #1;
      chk("af_zero", {31'b0, almost_full}, 32'd1);
      af_thresh = 5'd12;

      // Async reset mid-burst, between clock edges
      for (int i = 0; i < 4; i++) cycle(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
      cycle(1'b1, 8'h20, 1'b1, 1'b0);
      #2;
      rst = 1'b0;
      #1;
      chk("async_count", {27'b0, count}, 32'd0);
      chk("async_empty", {31'b0, empty}, 32'd1);
      chk("async_rd_valid", {31'b0, rd_valid}, 32'd0);
      model_reset();
      @(negedge clk) rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      cycle(1'b1, 8'h5A, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      chk("post_rst_data", {24'b0, rd_out}, 32'h5A);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_param.md
FIFO_PARAM -- requirements
Module: fifo_param

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, data word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 4, with DEPTH = 2**ADDR_W entries (16 by default) and legal range 2..12.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset; asserts immediately, deasserts synchronously to clk.
REQ-005 wr  input  1  write request.
REQ-006 wr_in  input  DATA_W  write data.
REQ-007 rd  input  1  read request.
REQ-008 rd_out  output  DATA_W  registered read data.
REQ-009 rd_valid  output  1  rd_out updated by the previous edge.
REQ-010 full  output  1  count == DEPTH.
REQ-011 empty  output  1  count == 0.
REQ-012 count  output  ADDR_W+1  current occupancy, 0..DEPTH.
REQ-013 af_thresh  input  ADDR_W+1  almost-full level.
REQ-014 ae_thresh  input  ADDR_W+1  almost-empty level.
REQ-015 almost_full  output  1  count >= af_thresh.
REQ-016 almost_empty  output  1  count <= ae_thresh.
REQ-017 overflow  output  1  sticky: a write was rejected.
REQ-018 underflow  output  1  sticky: a read was rejected.
REQ-019 err_clr  input  1  synchronous clear of overflow and underflow.

Function
REQ-020 Write and read pointers SHALL be ADDR_W+1 bits wide; count = wptr - rptr, modulo 2**(ADDR_W+1); all DEPTH entries are usable.
REQ-021 A write SHALL be accepted iff wr && !full, with full sampled before the edge; it stores wr_in at mem[wptr[ADDR_W-1:0]] and increments wptr.
REQ-022 A read SHALL be accepted iff rd && !empty; it loads rd_out <= mem[rptr[ADDR_W-1:0]] on the same edge, increments rptr, and sets rd_valid = 1 for exactly the next cycle.
REQ-023 When no read is accepted, rd_valid SHALL be 0 and rd_out SHALL hold its previous value.
REQ-024 Pointers SHALL wrap naturally; address bits wrap at DEPTH and the MSB toggles on each wrap.
REQ-025 Simultaneous accepted read and write SHALL leave count unchanged.
REQ-026 While full, a simultaneous wr && rd SHALL accept the read, reject the write, and set overflow; count ends at DEPTH-1.
REQ-027 While empty, a simultaneous wr && rd SHALL accept the write, reject the read, and set underflow; count ends at 1; rd_valid stays 0.
REQ-028 A rejected operation SHALL change neither pointers nor memory.
REQ-029 overflow SHALL be set on any cycle with wr && full and underflow on any cycle with rd && empty; both hold until err_clr.
REQ-030 If set and err_clr coincide in one cycle, the flag SHALL be set (set wins).
REQ-031 full, empty, count, almost_full and almost_empty SHALL be combinational from the pointers and thresholds; thresholds may change at any time.
REQ-032 af_thresh = 0 SHALL give almost_full = 1 constantly; ae_thresh >= DEPTH SHALL give almost_empty = 1 constantly.

Reset
REQ-033 On rst = 0, outputs SHALL take these values without waiting for clk: wptr = rptr = 0, count = 0, empty = 1, full = 0, rd_out = 0, rd_valid = 0, overflow = 0, underflow = 0.
REQ-034 Memory contents SHALL NOT be reset; reset mid-operation discards all stored data.
REQ-035 almost_full and almost_empty SHALL reflect count = 0 during reset.

Verification
REQ-036 Fill: 16 writes 0x00..0x0F from reset -> full = 1 after the 16th, count = 16; a 17th write -> overflow = 1, count stays 16.
REQ-037 Drain: 16 reads -> rd_out = 0x00..0x0F in order, each with rd_valid one cycle after the read; empty = 1 at the end; one further read -> underflow = 1, rd_out holds 0x0F.
REQ-038 Wrap: 10 writes, 10 reads, then 12 writes and 12 reads -> data order preserved, count returns to 0, pointer MSB toggled.
REQ-039 Boundaries: wr && rd for one cycle while full -> count = 15, overflow = 1; wr && rd for one cycle while empty -> count = 1, underflow = 1.
REQ-040 Thresholds and errors: af_thresh = 12, ae_thresh = 3 -> almost_full first rises at count 12 and almost_empty falls at count 4; err_clr coinciding with a new overflow leaves overflow = 1, and a lone err_clr clears it.
REQ-041 Async reset: drive rst low mid-burst between clock edges -> count = 0, empty = 1 and rd_valid = 0 immediately; the first write after release is read back correctly.
